// File: rtl/int_to_float_converter.sv
// -----------------------------------------------------------------------------
// int_to_float_converter
//
// Multi-cycle 32-bit integer to IEEE-754 single-precision converter covering
// FCVT.S.W (signed) and FCVT.S.WU (unsigned). It is the counterpart of the
// FPU's float-to-integer path and is driven by the FPU control: a conversion
// is issued with START, the pipeline stalls while BUSY is high, and RESULT is
// written back in the cycle VALID pulses.
//
// Normalisation shifts the magnitude left by one bit per cycle until its MSB
// is set. Latency from the accepting edge to the VALID cycle is lz+3 cycles,
// where lz is the number of leading zeros of the magnitude. The range is 3
// cycles for a normalised input or zero, and 34 cycles for a magnitude of 1.
//
// Build option:
//   I2F_ROUND_RNE_EN  defined   -> round-to-nearest-even
//                     undefined -> round-toward-zero (truncate)
//   INEXACT is reported identically in both builds. Latency and handshake
//   are also the same in both builds.
//
// Parameters:
//   EXP_BIAS  single-precision exponent bias (127). The starting exponent
//             is EXP_BIAS+31, which is the exponent of bit 31 of the magnitude.
//
// Ports:
//   CLK       in   1   clock, rising edge
//   RESET     in   1   synchronous, active-high reset
//   START     in   1   request a conversion (sampled only in IDLE)
//   UNSIGNED  in   1   1 = DATA is unsigned, 0 = two's complement
//   DATA      in   32  integer operand (sampled with START)
//   BUSY      out  1   conversion in flight (NORM/ROUND)
//   VALID     out  1   one-cycle pulse, RESULT/INEXACT valid
//   RESULT    out  32  float result, held until the next VALID
//   INEXACT   out  1   nonzero magnitude bits were discarded, held
// -----------------------------------------------------------------------------
module int_to_float_converter #(
  parameter int unsigned EXP_BIAS = 127
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        UNSIGNED,
  input  logic [31:0] DATA,
  output logic        BUSY,
  output logic        VALID,
  output logic [31:0] RESULT,
  output logic        INEXACT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Exponent of MAG[31] before any shifting.
  localparam logic [8:0] EXP_INIT = 9'(EXP_BIAS + 31);

  state_t      state;
  state_t      state_next;

  logic        sign_q;    // result sign; never set for an unsigned operand
  logic [31:0] mag_q;     // magnitude, shifted left during NORM
  logic [8:0]  exp_q;     // biased exponent that tracks mag_q[31]
  logic        zero_q;    // operand was zero, so the result is +0.0

  logic        accept;
  logic        sign_in;
  logic [31:0] mag_in;
  logic        norm_done;
  logic        mag_zero;

  // Rounding datapath signals. They are valid while the FSM is in ROUND.
  logic [22:0] frac_trunc;
  logic        guard_bit;
  logic        sticky_bit;
  logic        inexact_next;
  logic [22:0] frac_round;
  logic [8:0]  exp_round;
  logic [31:0] result_next;

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  assign accept  = (state == IDLE) && START;
  assign sign_in = DATA[31] & ~UNSIGNED;
  // Negating -2^31 wraps back to 0x80000000. That value is the correct
  // unsigned magnitude, so no overflow handling is needed.
  assign mag_in  = sign_in ? (~DATA + 32'd1) : DATA;

  // ---------------------------------------------------------------------------
  // Normalisation status
  // ---------------------------------------------------------------------------
  assign mag_zero  = (mag_q == 32'd0);
  assign norm_done = mag_zero || mag_q[31];

  // ---------------------------------------------------------------------------
  // Rounding
  // ---------------------------------------------------------------------------
  // After normalisation, MAG[31] is the hidden bit and MAG[30:8] is the
  // fraction. MAG[7] is the guard bit, and MAG[6:0] collapses to the sticky bit.
  assign frac_trunc   = mag_q[30:8];
  assign guard_bit    = mag_q[7];
  assign sticky_bit   = |mag_q[6:0];
  assign inexact_next = guard_bit | sticky_bit;

`ifdef I2F_ROUND_RNE_EN
  logic        lsb_bit;
  logic        round_up;
  logic [23:0] frac_sum;

  assign lsb_bit  = mag_q[8];
  // Round up above the halfway point. On an exact tie, round up only when
  // that makes the fraction even.
  assign round_up = guard_bit & (sticky_bit | lsb_bit);
  assign frac_sum = {1'b0, frac_trunc} + 24'(round_up);

  // A carry out of the fraction means the mantissa rounded up to 2.0.
  // The wrapped fraction is already zero, so only the exponent moves.
  // The largest possible result is 2^32, so the exponent stays below 255.
  assign frac_round = frac_sum[22:0];
  assign exp_round  = exp_q + 9'(frac_sum[23]);
`else
  // Round toward zero: the fraction is truncated and never carries.
  assign frac_round = frac_trunc;
  assign exp_round  = exp_q;
`endif

  // Zero bypasses the field packing so that the result is always +0.0.
  assign result_next = zero_q ? 32'd0 : {sign_q, exp_round[7:0], frac_round};

  // The exponent is at most 159 here, so bit 8 never reaches the result.
  logic unused_exp_msb;
  assign unused_exp_msb = exp_round[8];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so that
  // every register samples pre-edge values, independent of process order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first. Otherwise a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    VALID      = 1'b0;

    unique case (state)
      IDLE: begin
        if (START) begin
          state_next = NORM;
        end
      end

      NORM: begin
        BUSY = 1'b1;
        if (norm_done) begin
          state_next = ROUND;
        end
      end

      ROUND: begin
        BUSY       = 1'b1;
        state_next = DONE;
      end

      DONE: begin
        // START is ignored here. IDLE accepts a new operand on the next cycle.
        VALID      = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sign_q  <= 1'b0;
      mag_q   <= 32'd0;
      exp_q   <= 9'd0;
      zero_q  <= 1'b0;
      RESULT  <= 32'd0;
      INEXACT <= 1'b0;
    end else begin
      if (accept) begin
        sign_q <= sign_in;
        mag_q  <= mag_in;
        exp_q  <= EXP_INIT;
        zero_q <= 1'b0;
      end

      if (state == NORM) begin
        if (mag_zero) begin
          zero_q <= 1'b1;
        end else if (!mag_q[31]) begin
          // Each shift moves the leading one up one place. Decrementing the
          // exponent keeps the represented value unchanged.
          mag_q <= {mag_q[30:0], 1'b0};
          exp_q <= exp_q - 9'd1;
        end
      end

      // RESULT and INEXACT update only here, so they hold between VALIDs.
      if (state == ROUND) begin
        RESULT  <= result_next;
        INEXACT <= zero_q ? 1'b0 : inexact_next;
      end
    end
  end

endmodule

// File: tb/tb_int_to_float_converter.sv
module tb_int_to_float_converter;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        UNSIGNED;
  logic [31:0] DATA;
  logic        BUSY;
  logic        VALID;
  logic [31:0] RESULT;
  logic        INEXACT;

  int n_checks = 0;
  int n_fail   = 0;

  int_to_float_converter #(.EXP_BIAS(127)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .UNSIGNED (UNSIGNED),
    .DATA     (DATA),
    .BUSY     (BUSY),
    .VALID    (VALID),
    .RESULT   (RESULT),
    .INEXACT  (INEXACT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected values that depend on the rounding mode.
`ifdef I2F_ROUND_RNE_EN
  localparam logic [31:0] EXP_7FFFFFFF = 32'h4F00_0000;
  localparam logic [31:0] EXP_01000003 = 32'h4B80_0002;
  localparam logic [31:0] EXP_U_FFFFFFFF = 32'h4F80_0000;
`else
  localparam logic [31:0] EXP_7FFFFFFF = 32'h4EFF_FFFF;
  localparam logic [31:0] EXP_01000003 = 32'h4B80_0001;
  localparam logic [31:0] EXP_U_FFFFFFFF = 32'h4F7F_FFFF;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one conversion from an IDLE cycle and wait for VALID.
  // The task returns at the falling edge of the DONE cycle. The next call
  // therefore issues from the IDLE cycle straight after DONE.
  task automatic run_conv(input string tag, input logic [31:0] d, input logic u,
                          input logic [31:0] exp_res, input logic exp_inx,
                          input int exp_lat);
    int lat;
    bit seen;
    @(negedge CLK);
    START    = 1'b1;
    DATA     = d;
    UNSIGNED = u;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    // Operands may change freely once the converter has accepted them.
    START    = 1'b0;
    DATA     = ~d;
    UNSIGNED = ~u;
    check({tag, ".busy"}, 32'(BUSY), 32'd1);
    seen = 1'b0;
    while (!seen && lat < 100) begin
      if (VALID) begin
        seen = 1'b1;
      end else begin
        @(posedge CLK);
        @(negedge CLK);
        lat++;
      end
    end
    check({tag, ".valid_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, RESULT, exp_res);
    check({tag, ".inexact"}, 32'(INEXACT), 32'(exp_inx));
    check({tag, ".busy_at_valid"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_valid;
    bit drop;

    RESET    = 1'b1;
    START    = 1'b0;
    UNSIGNED = 1'b0;
    DATA     = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Reset state
    check("reset.busy",    32'(BUSY),    32'd0);
    check("reset.valid",   32'(VALID),   32'd0);
    check("reset.result",  RESULT,       32'd0);
    check("reset.inexact", 32'(INEXACT), 32'd0);

    // Directed conversions, issued back to back
    run_conv("s_one",      32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 34);
    run_conv("s_minus1",   32'hFFFF_FFFF, 1'b0, 32'hBF80_0000, 1'b0, 34);
    run_conv("s_min",      32'h8000_0000, 1'b0, 32'hCF00_0000, 1'b0, 3);
    run_conv("zero",       32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 3);
    run_conv("s_max",      32'h7FFF_FFFF, 1'b0, EXP_7FFFFFFF,  1'b1, 4);
    run_conv("tie_even",   32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 10);
    run_conv("tie_odd",    32'h0100_0003, 1'b0, EXP_01000003,  1'b1, 10);
    run_conv("u_max",      32'hFFFF_FFFF, 1'b1, EXP_U_FFFFFFFF, 1'b1, 3);
    run_conv("s_minus5",   32'hFFFF_FFFB, 1'b0, 32'hC0A0_0000, 1'b0, 32);

    // RESULT holds after the VALID pulse
    @(negedge CLK);
    check("hold.result", RESULT, 32'hC0A0_0000);
    check("hold.valid",  32'(VALID), 32'd0);

    // START held high through a 34-cycle conversion and its DONE cycle
    START    = 1'b1;
    DATA     = 32'h0000_0001;
    UNSIGNED = 1'b0;
    n_valid  = 0;
    drop     = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (drop) begin
        START = 1'b0;
      end else begin
        DATA = 32'h1234_5678 + 32'(i);
      end
      if (VALID) begin
        n_valid++;
        if (n_valid == 1) begin
          check("spam.result", RESULT, 32'h3F80_0000);
          drop = 1'b1;
        end
      end
    end
    check("spam.valid_count", 32'(n_valid), 32'd1);
    check("spam.busy_after",  32'(BUSY), 32'd0);

    // Reset during NORM cycle 10
    START    = 1'b1;
    DATA     = 32'h0000_0001;
    UNSIGNED = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("rst_mid.busy_before", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check("rst_mid.busy",    32'(BUSY),    32'd0);
    check("rst_mid.valid",   32'(VALID),   32'd0);
    check("rst_mid.result",  RESULT,       32'd0);
    check("rst_mid.inexact", 32'(INEXACT), 32'd0);
    n_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (VALID) n_valid++;
    end
    check("rst_mid.no_valid", 32'(n_valid), 32'd0);

    // A new conversion after the reset completes normally
    run_conv("post_rst", 32'h0000_0100, 1'b0, 32'h4380_0000, 1'b0, 26);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_to_float_converter.md
Name: int_to_float_converter

Overview:
- Multi-cycle converter from 32-bit integer to IEEE-754 single precision. Implements FCVT.S.W (signed) and FCVT.S.WU (unsigned).
- It is the inverse of the FPU's float-to-integer path.
- Sits beside the combinational FPU. The FPU control issues a conversion with START, stalls while BUSY is high, and writes RESULT back when VALID pulses.
- Normalisation uses an iterative one-bit-per-cycle left shift. This trades latency for area.

Parameters:
- EXP_BIAS, 127, single-precision exponent bias. The initial exponent is EXP_BIAS+31.

Ports:
- CLK  input  1  clock. All logic is on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request a conversion. Sampled only when BUSY=0.
- UNSIGNED  input  1  1 = treat DATA as unsigned (FCVT.S.WU); 0 = two's-complement (FCVT.S.W). Sampled with START.
- DATA  input  32  integer operand. Sampled with START.
- BUSY  output  1  high from the cycle after START is accepted until VALID is asserted.
- VALID  output  1  one-cycle pulse; RESULT and INEXACT are valid in that cycle.
- RESULT  output  32  float result. Holds its value until the next VALID.
- INEXACT  output  1  1 = discarded magnitude bits were nonzero. Holds until the next VALID.

Behaviour:
- Reset: state IDLE; BUSY=0, VALID=0, RESULT=0, INEXACT=0; internal registers cleared.
- One synchronous reset applies in every state. If RESET is asserted mid-operation, the operation is abandoned, no VALID is produced, and the block returns to IDLE on the next edge.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - On START=1, latch the sign: DATA[31]&~UNSIGNED.
  - Latch the 32-bit magnitude MAG: the two's complement of DATA if the sign is 1, else DATA. For -2^31 the magnitude is 0x80000000, with no overflow.
  - Set EXP = EXP_BIAS+31 (9-bit register). Go to NORM; BUSY=1.
- NORM:
  - If MAG==0: zero flag set, go to ROUND.
  - Else if MAG[31]==1: go to ROUND.
  - Else: MAG<<=1, EXP-=1, stay in NORM.
  - NORM therefore lasts lz+1 cycles, where lz = leading zeros (0..31).
- ROUND: compute the fields from the normalised MAG.
  - FRAC = MAG[30:8]; L = MAG[8]; G = MAG[7]; S = |MAG[6:0].
  - INEXACT_next = G|S.
  - Apply rounding as defined under the Optional Feature.
  - If FRAC+1 overflows 23 bits: FRAC=0, EXP+=1.
  - Register RESULT = {sign, EXP[7:0], FRAC}.
  - Zero input gives RESULT=0x00000000 and INEXACT=0. Zero is never negative.
  - Go to DONE.
- DONE: VALID=1 for exactly one cycle. BUSY is deasserted in the same cycle. Return to IDLE.
- Latency, START edge to VALID cycle: lz+3 cycles. Range is 3 (normalised input or zero) to 34 (magnitude 1).
- START while BUSY=1 or in DONE is ignored. No queueing.
- START in the IDLE cycle immediately following DONE is accepted. Back-to-back throughput is one conversion per lz+4 cycles.
- Exponent never underflows or overflows: the maximum rounded value is 2^32, giving exponent 159.
- DATA and UNSIGNED may change freely after acceptance.

Optional Feature:
- Macro: I2F_ROUND_RNE_EN.
- Defined: round-to-nearest-even. Increment FRAC when G & (S | L).
- Undefined: round-toward-zero (truncate). FRAC is never incremented, so the exponent-carry path is absent. INEXACT is still computed as G|S.
- Latency and handshake are identical in both builds.

Test Plan:
- Signed 1, then signed -1 (0xFFFFFFFF, UNSIGNED=0) -> RESULT=0x3F800000 and 0xBF800000 respectively. VALID occurs 34 cycles after START in each case. INEXACT=0.
- Signed 0x80000000 -> 0xCF000000, latency 3, INEXACT=0. Zero -> 0x00000000, latency 3.
- Signed 0x7FFFFFFF:
  - RNE build: 0x4F000000 (carry into exponent), INEXACT=1.
  - RTZ build: 0x4EFFFFFF, INEXACT=1.
- Ties, with INEXACT=1 in all cases:
  - 0x01000001 -> 0x4B800000 in both builds.
  - 0x01000003 -> 0x4B800002 in the RNE build; 0x4B800001 in the RTZ build.
- Unsigned 0xFFFFFFFF -> 0x4F800000 (RNE build) or 0x4F7FFFFF (RTZ build). The same DATA signed gives 0xBF800000.
- Handshake and reset:
  - START pulsed every cycle during a 34-cycle conversion -> exactly one VALID, and RESULT is from the first operand.
  - RESET asserted in NORM cycle 10 -> no VALID; BUSY=0, RESULT=0 next cycle.
  - A new START after RESET completes normally.
